// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one aligned req/ack bus transaction per load/store,
// with store lane replication, load alignment/extension and fault detection.
module mem_access_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        mem_read,
   input  logic [3:0]        mem_write,
   input  logic              mem_sign_extend,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              misalign,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state, state_nx;
   logic        write, access, legal, accept;
   logic [3:0]  mask;
   logic [31:0] lane_wdata, shifted, load_val;
   logic [1:0]  off_q;
   logic [3:0]  size_q;
   logic        sgn_q, rd_q;

   // a nonzero write mask takes priority over the read mask
   always_comb begin
      write      = |mem_write;
      mask       = write ? mem_write : mem_read;
      access     = |mask;
      legal      = 1'b0;
      lane_wdata = wdata;
      case (mask)
         4'b0001: begin
            legal      = 1'b1;
            lane_wdata = {4{wdata[7:0]}};
         end
         4'b0011: begin
            legal      = ~addr[0];
            lane_wdata = {2{wdata[15:0]}};
         end
         4'b1111: legal = (addr[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      shifted  = bus_rdata >> {off_q, 3'b000};
      load_val = shifted;
      case (size_q)
         4'b0001: load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
         4'b0011: load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      misalign = 1'b0;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (access && legal) begin
               accept   = 1'b1;
               stall    = 1'b1;
               state_nx = REQ;
            end else if (access) begin
               misalign = 1'b1;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (bus_ack)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // inputs may still present an access while reset is held
      if (reset) begin
         stall    = 1'b0;
         misalign = 1'b0;
         accept   = 1'b0;
      end
   end

   assign bus_req     = (state == REQ);
   assign rdata_valid = (state == DONE) && rd_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'h0;
         off_q     <= 2'b00;
         size_q    <= 4'b0000;
         sgn_q     <= 1'b0;
         rd_q      <= 1'b0;
         rdata     <= 32'h0;
      end else begin
         state <= state_nx;
         if (accept) begin
            bus_we    <= write;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= mask << addr[1:0];
            bus_wdata <= lane_wdata;
            off_q     <= addr[1:0];
            size_q    <= mask;
            sgn_q     <= mem_sign_extend;
            rd_q      <= ~write;
         end
         if (state == REQ && bus_ack && rd_q)
            rdata <= load_val;
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the decoded MEM-stage control signals (4-bit read/write byte-lane masks, sign-extend flag) and a single-port data-memory bus with a req/ack handshake. It turns one load or store into one aligned bus transaction and stalls the pipeline until the bus completes. It also lane-shifts store data, aligns and sign/zero-extends load data, and flags misaligned or illegal accesses.

## Interface
Parameters:
- ADDR_W, 32, byte-address width. Data width is fixed at 32.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  4  load lane mask: 0000 none, 0001 byte, 0011 half, 1111 word.
- mem_write  in  4  store lane mask, same encoding as mem_read.
- mem_sign_extend  in  1  1 = sign-extend load result, 0 = zero-extend.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  32  store data, right-justified.
- stall  out  1  holds the pipeline (PC and all stage registers).
- rdata  out  32  aligned, extended load result.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- misalign  out  1  one-cycle pulse on a faulting access.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word address (bits [1:0] = 00).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-positioned write data.
- bus_ack  in  1  completion. For reads, bus_rdata is valid in the same cycle.
- bus_rdata  in  32  raw read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- **Access present:** mem_write != 0 or mem_read != 0. If both are nonzero, the write wins and the read mask is ignored.
- **Legal masks:** 0001 with any address; 0011 with addr[0]=0; 1111 with addr[1:0]=00.
- **Illegal access (IDLE only):** any other mask value, or a legal mask at a misaligned address.
  - misalign = 1 for that cycle.
  - No bus request, stall = 0, state stays IDLE.
  - The access is dropped.
- **Legal access in IDLE:**
  - stall = 1 (combinational).
  - Register the transaction: bus_we; bus_addr = {addr[ADDR_W-1:2], 2'b00}; bus_be = mask << addr[1:0]; bus_wdata; load offset, size and sign flag.
  - Go to REQ.
- **Write data positioning:**
  - byte: wdata[7:0] replicated into all four lanes.
  - half: wdata[15:0] replicated into both halves.
  - word: wdata unchanged.
- **REQ:**
  - bus_req = 1. bus_we, bus_addr, bus_be and bus_wdata are held stable.
  - stall = 1.
  - On bus_ack: for reads, capture rdata = extend((bus_rdata >> 8*offset) masked to size); then go to DONE.
- **DONE:**
  - bus_req = 0, stall = 0.
  - rdata_valid = 1 if the access was a read.
  - The pipeline advances at the end of this cycle. The inputs still present the same access, so it is not re-issued.
  - Go to IDLE unconditionally.
- rdata holds its value until the next read completes.
- **Extension:**
  - byte: bit 7 replicated if sign flag set, else zero.
  - half: bit 15 replicated if sign flag set, else zero.
  - word: no extension.

## Timing
- **Reset:** reset asserted sends the FSM to IDLE immediately (asynchronous). Every output clears to 0: stall, rdata, rdata_valid, misalign, bus_req, bus_we, bus_addr, bus_be, bus_wdata. Reset during REQ drops bus_req in the same cycle, and the transaction is abandoned.
- **Latency:** a legal access takes 3 + W cycles from the first cycle it is presented in IDLE, where W = REQ cycles before the ack cycle (W=0 means ack in the first REQ cycle). stall is high for 2 + W cycles.
- **Handshake:**
  - bus_req rises in the cycle after acceptance and stays high until and including the ack cycle.
  - bus_ack while bus_req = 0 is ignored.
  - Bus outputs may change only in IDLE.
- **Back-to-back:** accesses are separated by at least one IDLE cycle, so bus_req has at least one low cycle between transactions.
- **Pulse outputs:** misalign and rdata_valid are each high for exactly one cycle per event.

## Test plan
- **Sign-extended byte load:** mem_read=0001, sign=1, addr=0x103; ack in the first REQ cycle with bus_rdata=0x80FF_FF00 -> bus_addr=0x100, bus_be=1000, bus_we=0; rdata=0xFFFF_FF80, rdata_valid for 1 cycle; stall high for 2 cycles.
- **Half store:** mem_write=0011, addr=0x202, wdata=0x1234_ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD; rdata_valid stays 0.
- **Waited word load:** mem_read=1111, addr=0x40, ack held off 3 REQ cycles, bus_rdata=0xDEAD_BEEF -> bus_req high for 4 cycles with stable address and byte enables; stall high for 5 cycles; rdata=0xDEAD_BEEF.
- **Zero- vs sign-extended half load:** mem_read=0011, addr=0x2, bus_rdata=0x8001_0000 -> sign=0 gives rdata=0x0000_8001; sign=1 gives rdata=0xFFFF_8001.
- **Faulting accesses:**
  - mem_read=1111 at addr=0x102 -> misalign pulse, bus_req never asserts, stall=0.
  - mem_write=0101 -> same response.
- **Reset mid-transaction:** assert reset during the 2nd REQ cycle -> bus_req and stall go to 0 asynchronously and all outputs return to reset values. After deassertion, a new LW at 0x10 completes normally.
